// File: rtl/booth_pkg.sv
// Shared types and helpers for the time-multiplexed radix-2 Booth multiplier.
// Holds the FSM state encoding and the round-robin search used by the arbiter.
package booth_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int MAX_REQ   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // First set bit of vld[n-1:0], scanning circularly upward from ptr.
    // Returns 0 when nothing is set; callers qualify with |vld.
    function automatic int rr_first(input logic [MAX_REQ-1:0] vld, input int n, input int ptr);
        int r;
        int j;
        r = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (vld[j]) r = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_radix2_step.sv
// One combinational radix-2 Booth iteration: add/sub M into A, then
// arithmetic-shift {A, Q, Q-1} right by one.
module booth_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_sum;

    // One guard bit keeps A exact when M or Y is the most negative value.
    assign w_m_ext = {i_m[WIDTH-1], i_m};

    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q1})
            2'b01:   w_sum = i_a + w_m_ext;
            2'b10:   w_sum = i_a - w_m_ext;
            default: w_sum = i_a;
        endcase
    end

    assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one iterative Booth multiplier among NUM_REQ
// clients; returns the tagged 2*WIDTH-bit product over a valid/ready port.
module booth_mult_scheduler
    import booth_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ*WIDTH-1:0] req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_z,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_m;
    logic             r_q1, w_q1_nxt;
    logic             w_found;
    logic             w_accept;
    logic [IDW-1:0]   w_gid;

    assign w_found = |req_valid;
    assign w_gid   = IDW'(rr_first(MAX_REQ'(req_valid), NUM_REQ, int'(r_rr_ptr)));

    booth_radix2_step #(.WIDTH(WIDTH)) u_step (
        .i_a  (r_a),
        .i_q  (r_q),
        .i_q1 (r_q1),
        .i_m  (r_m),
        .o_a  (w_a_nxt),
        .o_q  (w_q_nxt),
        .o_q1 (w_q1_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    req_ready   = NUM_REQ'(1) << w_gid;
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = DONE;
            end
            DONE: begin
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_q1     <= 1'b0;
            r_m      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_m      <= req_x[w_gid*WIDTH +: WIDTH];
                r_q      <= req_y[w_gid*WIDTH +: WIDTH];
                r_a      <= '0;
                r_q1     <= 1'b0;
                r_cnt    <= '0;
                r_id     <= w_gid;
                r_rr_ptr <= (w_gid == IDW'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
            end else if (r_state == RUN) begin
                r_a   <= w_a_nxt;
                r_q   <= w_q_nxt;
                r_q1  <= w_q1_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A and Q are untouched in IDLE, so the product lingers until the next accept.
    assign rsp_valid = (r_state == DONE);
    assign rsp_z     = {r_a[WIDTH-1:0], r_q};
    assign rsp_id    = r_id;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Scoreboard bench for booth_mult_scheduler: requests queue expected products,
// a monitor pops and compares on every response handshake.
module tb_booth_mult_scheduler;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_z;
    logic [IDW-1:0]   rsp_id;
    logic             busy;

    always #5 CLK = ~CLK;

    booth_mult_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_id(rsp_id), .busy(busy)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    z;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] qx[N][$];
    logic [W-1:0] qy[N][$];
    int           nvec = 0, nerr = 0;
    int           cyc = 0;
    int           acc_cyc = 0, acc_cnt = 0, acc_id = 0;
    int           rise_cyc = 0, hs_cyc = 0;
    bit           rnd_rdy = 1'b0;
    logic [N-1:0] drv_hs;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chk_ge(input string nm, input int act, input int lo);
        nvec++;
        if (act < lo) begin
            nerr++;
            $display("FAIL %s: got %0d expected at least %0d", nm, act, lo);
        end
    endtask

    function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic int npend();
        int s = 0;
        for (int i = 0; i < N; i++) s += qx[i].size();
        return s;
    endfunction

    task automatic push_req(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [63:0] z);
        exp_t e;
        qx[id].push_back(x);
        qy[id].push_back(y);
        e.id = IDW'(id);
        e.z  = z;
        exp_q.push_back(e);
    endtask

    task automatic wait_acc(input int target);
        int k = 0;
        while (acc_cnt < target && k < 400) begin
            @(posedge CLK); #2;
            k++;
        end
        nvec++;
        if (acc_cnt < target) begin
            nerr++;
            $display("FAIL accept_timeout: got %0d accepts expected %0d", acc_cnt, target);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || npend() != 0 || busy) && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        nvec++;
        if (k >= 3000) begin
            nerr++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    // Request driver: presents queued operands, retires them on handshake.
    initial begin
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        forever begin
            @(negedge CLK);
            drv_hs = req_valid & req_ready;
            @(posedge CLK); #1;
            for (int i = 0; i < N; i++) begin
                if (drv_hs[i]) begin
                    void'(qx[i].pop_front());
                    void'(qy[i].pop_front());
                    acc_cyc = cyc;
                    acc_id  = i;
                    acc_cnt++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (qx[i].size() > 0) begin
                    req_valid[i]      = 1'b1;
                    req_x[i*W +: W]   = qx[i][0];
                    req_y[i*W +: W]   = qy[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            if (rnd_rdy) rsp_ready = ($urandom_range(3) != 0);
        end
    end

    // Response monitor: scoreboard pop, hold-under-stall and ready-gating checks.
    initial begin
        bit             pv, pstall;
        logic [63:0]    sz;
        logic [IDW-1:0] sid;
        exp_t           e;
        pv = 1'b0;
        pstall = 1'b0;
        sz = '0;
        sid = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                pv = 1'b0;
                pstall = 1'b0;
            end else begin
                if (rsp_valid && !pv) rise_cyc = cyc;
                if (rsp_valid) chk("ready_zero_in_done", 64'(req_ready), 64'd0);
                if (pstall) begin
                    chk("hold_valid", 64'(rsp_valid), 64'd1);
                    chk("hold_z", rsp_z, sz);
                    chk("hold_id", 64'(rsp_id), 64'(sid));
                end
                if (rsp_valid && rsp_ready) begin
                    hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_rsp: got id %0d z %h expected no response",
                                 rsp_id, rsp_z);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_z", rsp_z, e.z);
                    end
                end
                pstall = rsp_valid && !rsp_ready;
                sz     = rsp_z;
                sid    = rsp_id;
                pv     = rsp_valid;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          base, lat, prev, id;
        bit          bz;
        logic [31:0] x, y;
        logic [31:0] corners[6];
        corners = '{32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000001};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_z", rsp_z, 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Single op from requester 2: 7 * -3.
        base = acc_cnt;
        push_req(2, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB);
        wait_acc(base + 1);
        chk("accept_id", 64'(acc_id), 64'd2);
        bz = 1'b1;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge CLK);
            lat++;
            if (!rsp_valid && !busy) bz = 1'b0;
        end
        chk("busy_during_run", 64'(bz), 64'd1);
        wait_drain();
        chk("latency", 64'(rise_cyc - acc_cyc), 64'd32);

        // Corner operands.
        push_req(3, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        wait_drain();
        push_req(0, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000);
        wait_drain();
        push_req(1, 32'h00000000, 32'h7FFFFFFF, 64'h0);
        wait_drain();

        // Backpressure with a second requester waiting behind the stalled result.
        rsp_ready = 1'b0;
        base = acc_cnt;
        push_req(1, 32'd12345, 32'hFFFFFD5A, 64'hFFFFFFFF_FF80490A);
        wait_acc(base + 1);
        push_req(0, 32'd2, 32'd3, 64'd6);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        repeat (10) @(negedge CLK);
        chk("bp_ready_zero", 64'(req_ready), 64'd0);
        chk("bp_still_valid", 64'(rsp_valid), 64'd1);
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        wait_acc(base + 2);
        chk_ge("bubble_after_rsp", acc_cyc - hs_cyc, 2);
        wait_drain();

        // Reset while requester 1 is mid-run.
        base = acc_cnt;
        push_req(1, 32'd100, 32'd200, 64'd20000);
        wait_acc(base + 1);
        repeat (15) @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
        repeat (5) @(negedge CLK);
        push_req(3, 32'hFFFFFFFB, 32'hFFFFFFFA, 64'd30);
        wait_drain();

        // Fairness: all requesters valid at once, requester 0 twice.
        base = acc_cnt;
        push_req(0, 32'd3, 32'd5, 64'd15);
        push_req(1, 32'hFFFFFFFE, 32'd9, 64'hFFFFFFFF_FFFFFFEE);
        push_req(2, 32'd100, 32'hFFFFFF9C, 64'hFFFFFFFF_FFFFD8F0);
        push_req(3, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001);
        push_req(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
        prev = 0;
        for (int k = 1; k <= 5; k++) begin
            wait_acc(base + k);
            if (k > 1) chk_ge("accept_gap", acc_cyc - prev, 34);
            prev = acc_cyc;
        end
        wait_drain();

        // Random regression with random response stalls.
        rnd_rdy = 1'b1;
        base = acc_cnt;
        for (int k = 0; k < 300; k++) begin
            id = $urandom_range(N - 1);
            x  = ($urandom_range(7) == 0) ? corners[$urandom_range(5)] : $urandom;
            y  = ($urandom_range(7) == 0) ? corners[$urandom_range(5)] : $urandom;
            push_req(id, x, y, mul(x, y));
            wait_acc(base + k + 1);
        end
        wait_drain();
        rnd_rdy = 1'b0;
        rsp_ready = 1'b1;
        chk("rand_accepts", 64'(acc_cnt - base), 64'd300);
        chk("rand_all_answered", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
